// File: rtl/complement_pkg.sv
// Shared types for the bit/digit-serial complement unit: operation modes and FSM states.
package complement_pkg;
  typedef enum logic [1:0] {
    MODE_ABS   = 2'd0,
    MODE_NEG   = 2'd1,
    MODE_TC2SM = 2'd2,
    MODE_SM2TC = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/complement_digit.sv
// One digit of serial two's-complement negation: optional invert plus carry-in, carry-out.
module complement_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] bits,
  input  logic             neg,
  input  logic             cin,
  output logic [DIGIT-1:0] dout,
  output logic             cout
);
  logic [DIGIT:0] sum;

  assign sum  = {1'b0, ~bits} + {{DIGIT{1'b0}}, cin};
  // Pass-through digits leave the carry untouched; it is only consumed when negating.
  assign dout = neg ? sum[DIGIT-1:0] : bits;
  assign cout = neg ? sum[DIGIT] : cin;
endmodule

// File: rtl/complement_serial.sv
// Digit-serial ABS/NEG/TC2SM/SM2TC unit with valid/ready handshakes on both sides.
module complement_serial
  import complement_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Q,
  output logic             ovf
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0]    LAST    = CW'(NDIG - 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  if (WIDTH < 2) begin : g_width_chk
    $error("complement_serial: WIDTH must be >= 2");
  end
  if (WIDTH % DIGIT != 0) begin : g_digit_chk
    $error("complement_serial: WIDTH must be a multiple of DIGIT");
  end

  state_t           state;
  mode_t            mode_r, mode_in;
  logic [WIDTH-1:0] w, w_nxt, res;
  logic [CW-1:0]    cnt;
  logic             carry, neg, ovf_pend;
  logic [DIGIT-1:0] dig;
  logic             cout, accept;

  assign mode_in   = mode_t'(mode);
  assign in_ready  = (state == ST_IDLE) || (state == ST_DONE && out_ready);
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid && in_ready;

  complement_digit #(.DIGIT(DIGIT)) u_digit (
    .bits (w[DIGIT-1:0]),
    .neg  (neg),
    .cin  (carry),
    .dout (dig),
    .cout (cout)
  );

  // Result digits enter at the MSB so the word is fully rotated after NDIG cycles.
  if (DIGIT == WIDTH) begin : g_full
    assign w_nxt = dig;
  end else begin : g_shift
    assign w_nxt = {dig, w[WIDTH-1:DIGIT]};
  end

  always_comb begin
    res = w_nxt;
    if (mode_r == MODE_TC2SM && neg)
      res = ovf_pend ? '1 : {1'b1, w_nxt[WIDTH-2:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      mode_r   <= MODE_ABS;
      w        <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      neg      <= 1'b0;
      ovf_pend <= 1'b0;
      Q        <= '0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            // SM2TC works on the magnitude only; the sign bit just selects negation.
            w        <= (mode_in == MODE_SM2TC) ? {1'b0, A[WIDTH-2:0]} : A;
            mode_r   <= mode_in;
            cnt      <= '0;
            carry    <= 1'b1;
            neg      <= (mode_in == MODE_NEG) ? 1'b1 : A[WIDTH-1];
            ovf_pend <= (A == MIN_VAL) && (mode_in != MODE_SM2TC);
            state    <= ST_RUN;
          end else if (state == ST_DONE && out_ready) begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          w     <= w_nxt;
          carry <= cout;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            Q     <= res;
            ovf   <= ovf_pend;
            state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_complement_serial.sv
// Bench for complement_serial: 8-bit/1-digit and 16-bit/4-digit instances with a scoreboard.
module tb_complement_serial;
  typedef struct {
    logic [15:0] q;
    logic        ovf;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0]       iv = '0, ordy = '1;
  logic [1:0][15:0] av = '0;
  logic [1:0][1:0]  md = '0;
  logic ir8, ir16, ov8, ov16, ovf8, ovf16;
  logic [7:0]  q8;
  logic [15:0] q16;
  logic [1:0]  ir, ov;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t sb [2][$];

  assign ir = {ir16, ir8};
  assign ov = {ov16, ov8};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  complement_serial #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir8), .A(av[0][7:0]),
    .mode(md[0]), .out_valid(ov8), .out_ready(ordy[0]), .Q(q8), .ovf(ovf8)
  );

  complement_serial #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir16), .A(av[1]),
    .mode(md[1]), .out_valid(ov16), .out_ready(ordy[1]), .Q(q16), .ovf(ovf16)
  );

  // Arithmetic reference, independent of the serial datapath.
  function automatic exp_t ref_m(int w, logic [15:0] a, logic [1:0] m);
    exp_t e;
    int mask, ai, r;
    bit s, mn;
    mask = (1 << w) - 1;
    ai   = int'(a) & mask;
    s    = ((ai >> (w - 1)) & 1) != 0;
    mn   = (ai == (1 << (w - 1)));
    case (m)
      2'd0:    begin r = s ? ((-ai) & mask) : ai; e.ovf = mn; end
      2'd1:    begin r = (-ai) & mask; e.ovf = mn; end
      2'd2:    begin r = !s ? ai : (mn ? mask : ((1 << (w - 1)) | ((-ai) & mask))); e.ovf = mn; end
      default: begin r = !s ? ai : ((-(ai & (mask >> 1))) & mask); e.ovf = 1'b0; end
    endcase
    e.q   = 16'(r);
    e.acc = 0;
    return e;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : mon
    logic        prev = 1'b0;
    exp_t        e;
    logic [15:0] obs;
    logic        obs_ovf;
    always @(negedge clk) begin
      if (!rst_n) prev = 1'b0;
      else begin
        obs     = (g == 0) ? {8'h00, q8} : q16;
        obs_ovf = (g == 0) ? ovf8 : ovf16;
        if (ov[g] && !prev) begin
          checks++;
          assert (sb[g].size() > 0) else begin
            errors++; $error("FAIL spurious_out%0d: out_valid=1 required=0", g);
          end
          if (sb[g].size() > 0) begin
            checks++;
            assert ((cyc - sb[g][0].acc) == ((g == 0) ? 8 : 4)) else begin
              errors++; $error("FAIL latency%0d: got=%0d required=%0d", g, cyc - sb[g][0].acc, (g == 0) ? 8 : 4);
            end
          end
        end
        if (ov[g] && ordy[g] && sb[g].size() > 0) begin
          e = sb[g].pop_front();
          checks += 2;
          assert (obs === e.q) else begin
            errors++; $error("FAIL q%0d: got=%h required=%h", g, obs, e.q);
          end
          assert (obs_ovf === e.ovf) else begin
            errors++; $error("FAIL ovf%0d: got=%b required=%b", g, obs_ovf, e.ovf);
          end
        end
        if (iv[g] && ir[g]) begin
          e = ref_m((g == 0) ? 8 : 16, av[g], md[g]);
          e.acc = cyc + 1;
          sb[g].push_back(e);
        end
        prev = ov[g];
      end
    end
  end

  task automatic send(int g, logic [15:0] a, logic [1:0] m);
    int n = 0;
    logic acc;
    iv[g] = 1'b1; av[g] = a; md[g] = m;
    do begin
      @(negedge clk); acc = ir[g];
      @(posedge clk); #1; n++;
    end while (!acc && n < 200);
    iv[g] = 1'b0;
    checks++;
    assert (acc) else begin errors++; $error("FAIL accept_timeout%0d: in_ready=0 required=1", g); end
  endtask

  task automatic drain(int g);
    int n = 0;
    while (sb[g].size() > 0 && n < 200) begin @(posedge clk); n++; end
    #1;
    checks++;
    assert (sb[g].size() == 0) else begin
      errors++; $error("FAIL drain%0d: pending=%0d required=0", g, sb[g].size());
    end
  endtask

  initial begin
    int n;
    #3;
    checks += 4;
    assert (ov8 === 1'b0) else begin errors++; $error("FAIL rst_valid: got=%b required=0", ov8); end
    assert (q8 === 8'h00) else begin errors++; $error("FAIL rst_q: got=%h required=00", q8); end
    assert (ovf8 === 1'b0) else begin errors++; $error("FAIL rst_ovf: got=%b required=0", ovf8); end
    assert (q16 === 16'h0000) else begin errors++; $error("FAIL rst_q16: got=%h required=0000", q16); end
    #19 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    assert (ir8 === 1'b1) else begin errors++; $error("FAIL rst_ready: got=%b required=1", ir8); end
    @(posedge clk); #1;

    // directed 8-bit cases
    send(0, 16'h00F6, 2'd0);
    @(negedge clk);
    checks += 2;
    assert (ov8 === 1'b0) else begin errors++; $error("FAIL run_valid: got=%b required=0", ov8); end
    assert (ir8 === 1'b0) else begin errors++; $error("FAIL run_ready: got=%b required=0", ir8); end
    @(posedge clk); #1;
    drain(0);
    send(0, 16'h0080, 2'd1);
    send(0, 16'h0005, 2'd1);
    send(0, 16'h00FB, 2'd2);
    send(0, 16'h0080, 2'd2);
    send(0, 16'h0085, 2'd3);
    send(0, 16'h0080, 2'd3);
    send(0, 16'h0080, 2'd0);
    send(0, 16'h0000, 2'd1);
    send(0, 16'h007F, 2'd0);
    drain(0);

    // held output, then back-to-back acceptance
    ordy[0] = 1'b0;
    send(0, 16'h0005, 2'd1);
    n = 0;
    do begin @(negedge clk); n++; end while (!ov8 && n < 50);
    repeat (5) begin
      @(negedge clk);
      checks += 4;
      assert (ov8 === 1'b1) else begin errors++; $error("FAIL hold_valid: got=%b required=1", ov8); end
      assert (q8 === 8'hFB) else begin errors++; $error("FAIL hold_q: got=%h required=fb", q8); end
      assert (ovf8 === 1'b0) else begin errors++; $error("FAIL hold_ovf: got=%b required=0", ovf8); end
      assert (ir8 === 1'b0) else begin errors++; $error("FAIL hold_ready: got=%b required=0", ir8); end
    end
    @(posedge clk); #1;
    ordy[0] = 1'b1;
    send(0, 16'h00F6, 2'd0);
    drain(0);

    // 16-bit, 4-bit digits
    send(1, 16'h0001, 2'd1);
    send(1, 16'h8000, 2'd1);
    send(1, 16'h8000, 2'd3);
    send(1, 16'h8000, 2'd2);
    send(1, 16'hFFFF, 2'd0);
    for (int i = 0; i < 30; i++) send(1, 16'($urandom), 2'($urandom_range(0, 3)));
    for (int i = 0; i < 20; i++) send(0, 16'($urandom_range(0, 255)), 2'($urandom_range(0, 3)));
    drain(1);
    drain(0);

    // reset in the middle of RUN
    send(0, 16'h0033, 2'd1);
    repeat (3) @(posedge clk);
    #1;
    sb[0].delete();
    rst_n = 1'b0;
    #1;
    checks += 3;
    assert (ov8 === 1'b0) else begin errors++; $error("FAIL midrst_valid: got=%b required=0", ov8); end
    assert (q8 === 8'h00) else begin errors++; $error("FAIL midrst_q: got=%h required=00", q8); end
    assert (ovf8 === 1'b0) else begin errors++; $error("FAIL midrst_ovf: got=%b required=0", ovf8); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    assert (ir8 === 1'b1) else begin errors++; $error("FAIL midrst_ready: got=%b required=1", ir8); end
    repeat (12) begin
      @(negedge clk);
      checks++;
      assert (ov8 === 1'b0) else begin errors++; $error("FAIL midrst_spurious: got=%b required=0", ov8); end
    end
    @(posedge clk); #1;
    send(0, 16'h00F6, 2'd0);
    drain(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
